// File: rtl/multi_cycle_mem_responder.sv
// Memory responder for the multicycle CPU: it latches one request, waits a fixed latency,
// then performs the word access and returns a single-cycle ready or err pulse.
module multi_cycle_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   din_q;
  logic          write_q;
  logic          fault_q;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          req_fault;
  logic          exec;
  logic          mem_we;

  assign req       = mem_read | mem_write;
  assign req_fault = (mem_read & mem_write) | (addr[1:0] != 2'b00) |
                     (addr[31:AW+2] != '0);
  assign exec      = (state_q == StBusy) && (cnt_q == 4'd0);
  // An asynchronous reset forces state_q to StIdle, so an aborted write never commits.
  assign mem_we    = exec & write_q & ~fault_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= din_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      din_q   <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      dout    <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= addr[AW+1:2];
            din_q   <= din;
            write_q <= mem_write;
            fault_q <= req_fault;
            cnt_q   <= 4'(LATENCY - 1);
            busy    <= 1'b1;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StResp;
            if (fault_q) begin
              err  <= 1'b1;
              dout <= '0;
            end else begin
              ready <= 1'b1;
              // Writes echo the stored data back on dout.
              dout  <= write_q ? din_q : mem[idx_q];
            end
          end
        end
        StResp: begin
          // This edge never samples a request, enforcing LATENCY+2 spacing.
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// Directed bench for multi_cycle_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_multi_cycle_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        rd0, wr0, ready0, err0, busy0;
  logic [31:0] addr0, din0, dout0;
  logic        rd1, wr1, ready1, err1, busy1;
  logic [31:0] addr1, din1, dout1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_cycle_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (rd0),
    .mem_write (wr0),
    .addr      (addr0),
    .din       (din0),
    .dout      (dout0),
    .ready     (ready0),
    .err       (err0),
    .busy      (busy0)
  );

  multi_cycle_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (rd1),
    .mem_write (wr1),
    .addr      (addr1),
    .din       (din1),
    .dout      (dout1),
    .ready     (ready1),
    .err       (err1),
    .busy      (busy1)
  );

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
    end
  endtask

  // Called 1 time unit after a rising edge; samples 1 unit after each of the next 4 edges.
  task automatic run_access(input int sel, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [3:0] rdy_h, output logic [3:0] err_h,
                            output logic [3:0] busy_h, output logic [31:0] dout_resp,
                            output logic [31:0] dout_after);
    int resp_i;
    resp_i = (sel == 0) ? 2 : 1;
    dout_resp = '0;
    drive(sel, rd, wr, a, d);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      rdy_h[i]  = (sel == 0) ? ready0 : ready1;
      err_h[i]  = (sel == 0) ? err0 : err1;
      busy_h[i] = (sel == 0) ? busy0 : busy1;
      if (i == resp_i) dout_resp = (sel == 0) ? dout0 : dout1;
    end
    dout_after = (sel == 0) ? dout0 : dout1;
  endtask

  task automatic test_reset();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", ready0); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_cmp++; if (dout0 !== 32'h0) begin n_bad++; $display("FAIL reset_dout got=%h exp=0", dout0); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_access(0, 1'b0, 1'b1, 32'h10, 32'h0, r, e, b, dr, da);
    run_access(0, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, r, e, b, dr, da);
    n_cmp++; if (dr !== 32'hCAFEF00D) begin n_bad++; $display("FAIL pre_abort_dout got=%h exp=cafef00d", dr); end
    // Start a write, then reset while it is in BUSY.
    drive(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got=%b exp=1", busy0); end
    reset = 1'b0;
    #1;
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy0); end
    n_cmp++; if (dout0 !== 32'h0) begin n_bad++; $display("FAIL abort_dout got=%h exp=0", dout0); end
    repeat (2) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (ready0 !== 1'b0 || err0 !== 1'b0 || busy0 !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_hold got=r%b e%b b%b exp=r0 e0 b0", ready0, err0, busy0);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, r, e, b, dr, da);
    n_cmp++; if (dr !== 32'h0) begin n_bad++; $display("FAIL abort_no_write got=%h exp=0", dr); end
    n_cmp++; if (r !== 4'b0100) begin n_bad++; $display("FAIL abort_read_ready got=%b exp=0100", r); end
  endtask

  task automatic test_write_read();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    run_access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, r, e, b, dr, da);
    n_cmp++; if (r !== 4'b0100) begin n_bad++; $display("FAIL wr_ready got=%b exp=0100", r); end
    n_cmp++; if (e !== 4'b0000) begin n_bad++; $display("FAIL wr_err got=%b exp=0000", e); end
    n_cmp++; if (b !== 4'b0111) begin n_bad++; $display("FAIL wr_busy got=%b exp=0111", b); end
    n_cmp++; if (dr !== 32'h12345678) begin n_bad++; $display("FAIL wr_echo got=%h exp=12345678", dr); end
    run_access(0, 1'b1, 1'b0, 32'h40, 32'h0, r, e, b, dr, da);
    n_cmp++; if (r !== 4'b0100) begin n_bad++; $display("FAIL rd_ready got=%b exp=0100", r); end
    n_cmp++; if (b !== 4'b0111) begin n_bad++; $display("FAIL rd_busy got=%b exp=0111", b); end
    n_cmp++; if (dr !== 32'h12345678) begin n_bad++; $display("FAIL rd_data got=%h exp=12345678", dr); end
    n_cmp++; if (da !== 32'h12345678) begin n_bad++; $display("FAIL rd_hold got=%h exp=12345678", da); end
  endtask

  task automatic test_input_change();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    run_access(0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, r, e, b, dr, da);
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 32'h44, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    n_cmp++; if (ready0 !== 1'b0) begin n_bad++; $display("FAIL chg_early_ready got=%b exp=0", ready0); end
    @(posedge clk);
    #1;
    n_cmp++; if (ready0 !== 1'b1) begin n_bad++; $display("FAIL chg_ready got=%b exp=1", ready0); end
    n_cmp++; if (dout0 !== 32'h12345678) begin n_bad++; $display("FAIL chg_data got=%h exp=12345678", dout0); end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    run_access(0, 1'b1, 1'b0, 32'h44, 32'h0, r, e, b, dr, da);
    n_cmp++; if (dr !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL chg_untouched got=%h exp=a5a5a5a5", dr); end
  endtask

  task automatic test_errors();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    run_access(0, 1'b1, 1'b1, 32'h40, 32'h11111111, r, e, b, dr, da);
    n_cmp++; if (e !== 4'b0100) begin n_bad++; $display("FAIL both_err got=%b exp=0100", e); end
    n_cmp++; if (r !== 4'b0000) begin n_bad++; $display("FAIL both_ready got=%b exp=0000", r); end
    n_cmp++; if (dr !== 32'h0) begin n_bad++; $display("FAIL both_dout got=%h exp=0", dr); end
    n_cmp++; if (b !== 4'b0111) begin n_bad++; $display("FAIL both_busy got=%b exp=0111", b); end
    run_access(0, 1'b0, 1'b1, 32'h42, 32'h22222222, r, e, b, dr, da);
    n_cmp++; if (e !== 4'b0100) begin n_bad++; $display("FAIL misalign_err got=%b exp=0100", e); end
    n_cmp++; if (da !== 32'h0) begin n_bad++; $display("FAIL misalign_hold got=%h exp=0", da); end
    run_access(0, 1'b1, 1'b0, 32'h40, 32'h0, r, e, b, dr, da);
    n_cmp++; if (dr !== 32'h12345678) begin n_bad++; $display("FAIL err_no_write got=%h exp=12345678", dr); end
    run_access(0, 1'b0, 1'b1, 32'h0, 32'h01010101, r, e, b, dr, da);
    run_access(0, 1'b0, 1'b1, 32'h1000, 32'h33333333, r, e, b, dr, da);
    n_cmp++; if (e !== 4'b0100) begin n_bad++; $display("FAIL range_err got=%b exp=0100", e); end
    n_cmp++; if (r !== 4'b0000) begin n_bad++; $display("FAIL range_ready got=%b exp=0000", r); end
    run_access(0, 1'b1, 1'b0, 32'h0, 32'h0, r, e, b, dr, da);
    n_cmp++; if (dr !== 32'h01010101) begin n_bad++; $display("FAIL range_no_wrap got=%h exp=01010101", dr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    logic [13:0] rv, bv;
    run_access(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, r, e, b, dr, da);
    rv = '0;
    bv = '0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int j = 1; j < 14; j++) begin
      @(posedge clk);
      #1;
      rv[j] = ready0;
      bv[j] = busy0;
      if (ready0 === 1'b1) begin
        n_cmp++;
        if (dout0 !== 32'h0BADF00D) begin
          n_bad++;
          $display("FAIL b2b_data cycle=%0d got=%h exp=0badf00d", j, dout0);
        end
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (rv !== 14'h0888) begin n_bad++; $display("FAIL b2b_ready got=%h exp=0888", rv); end
    n_cmp++; if (bv !== 14'h2EEE) begin n_bad++; $display("FAIL b2b_busy got=%h exp=2eee", bv); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", busy0); end
  endtask

  task automatic test_latency1();
    logic [3:0] r, e, b;
    logic [31:0] dr, da;
    run_access(1, 1'b0, 1'b1, 32'hFFC, 32'h5EEDFACE, r, e, b, dr, da);
    n_cmp++; if (r !== 4'b0010) begin n_bad++; $display("FAIL l1_wr_ready got=%b exp=0010", r); end
    n_cmp++; if (b !== 4'b0011) begin n_bad++; $display("FAIL l1_wr_busy got=%b exp=0011", b); end
    n_cmp++; if (dr !== 32'h5EEDFACE) begin n_bad++; $display("FAIL l1_wr_echo got=%h exp=5eedface", dr); end
    run_access(1, 1'b1, 1'b0, 32'hFFC, 32'h0, r, e, b, dr, da);
    n_cmp++; if (r !== 4'b0010) begin n_bad++; $display("FAIL l1_rd_ready got=%b exp=0010", r); end
    n_cmp++; if (dr !== 32'h5EEDFACE) begin n_bad++; $display("FAIL l1_rd_data got=%h exp=5eedface", dr); end
    run_access(1, 1'b1, 1'b0, 32'h1000, 32'h0, r, e, b, dr, da);
    n_cmp++; if (e !== 4'b0010) begin n_bad++; $display("FAIL l1_range_err got=%b exp=0010", e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_input_change();
    test_errors();
    test_back_to_back();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
